rvh_l1d_mshr_file: RTL

- Parametrised miss-status holding register file for one L1D bank; successor to the fixed single-port MSHR bank.
- Internally picks the free entry and tracks each entry with an explicit FSM.
- Issues AXI-style AR requests oldest-first with a configurable issue gap and marks in-flight loads no-response on ROB flush.
- Sits between the bank's s2 miss-handling pipeline and the L2 request NoC; the MLFB deallocates entries.

---
 rtl/rvh_l1d_mshr_file_if.sv | 44 ++++
 rtl/rvh_l1d_mshr_file.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rvh_l1d_mshr_file_if.sv
// Allocation, release, flush and AR request signals of one L1D bank MSHR file.
// slave: the MSHR file itself. master: the s2 miss pipeline / MLFB / NoC side.
interface rvh_l1d_mshr_file_if #(
  parameter int N_ENTRY     = 8,
  parameter int LINE_ADDR_W = 34
);
  localparam int ID_W = $clog2(N_ENTRY);

  logic                   alloc_vld_i;
  logic                   alloc_rdy_o;
  logic [LINE_ADDR_W-1:0] alloc_line_addr_i;
  logic                   alloc_is_load_i;
  logic                   alloc_no_fetch_i;
  logic [ID_W-1:0]        alloc_id_o;
  logic                   alloc_merge_o;
  logic                   dealloc_vld_i;
  logic [ID_W-1:0]        dealloc_id_i;
  logic                   rob_flush_i;
  logic                   ar_vld_o;
  logic                   ar_rdy_i;
  logic [ID_W-1:0]        ar_id_o;
  logic [1:0]             ar_bid_o;
  logic [LINE_ADDR_W-1:0] ar_addr_o;
  logic [N_ENTRY-1:0]     entry_vld_o;
  logic [N_ENTRY-1:0]     entry_sent_o;
  logic [N_ENTRY-1:0]     entry_no_resp_o;
  logic [ID_W:0]          free_cnt_o;

  modport slave (
    input  alloc_vld_i, alloc_line_addr_i, alloc_is_load_i, alloc_no_fetch_i,
    input  dealloc_vld_i, dealloc_id_i, rob_flush_i, ar_rdy_i,
    output alloc_rdy_o, alloc_id_o, alloc_merge_o,
    output ar_vld_o, ar_id_o, ar_bid_o, ar_addr_o,
    output entry_vld_o, entry_sent_o, entry_no_resp_o, free_cnt_o
  );

  modport master (
    output alloc_vld_i, alloc_line_addr_i, alloc_is_load_i, alloc_no_fetch_i,
    output dealloc_vld_i, dealloc_id_i, rob_flush_i, ar_rdy_i,
    input  alloc_rdy_o, alloc_id_o, alloc_merge_o,
    input  ar_vld_o, ar_id_o, ar_bid_o, ar_addr_o,
    input  entry_vld_o, entry_sent_o, entry_no_resp_o, free_cnt_o
  );
endinterface

// File: rtl/rvh_l1d_mshr_file.sv
// Miss-status holding register file for one L1D bank.
// Lowest-free-index allocation, per-entry FREE/PEND/SENT/HOLD FSM, oldest-first
// AR issue through an id FIFO with an optional idle gap, and load no_resp
// marking on ROB flush.
// Optional feature: define RVH_L1D_MSHR_MERGE_EN to merge a miss into an
// existing non-FREE entry with the same line address instead of allocating.
module rvh_l1d_mshr_file #(
  parameter int N_ENTRY     = 8,
  parameter int ID_W        = $clog2(N_ENTRY),
  parameter int LINE_ADDR_W = 34,
  parameter int BANK_ID     = 0,
  parameter int ISSUE_GAP   = 1
) (
  input  logic               clk,
  input  logic               rst,
  rvh_l1d_mshr_file_if.slave bus
);

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_PEND = 2'd1,
    ST_SENT = 2'd2,
    ST_HOLD = 2'd3
  } entry_state_e;

  localparam logic [ID_W:0] LP_N_ENTRY = (ID_W+1)'(N_ENTRY);
  localparam logic          LP_GAP     = (ISSUE_GAP != 0);
  localparam logic [1:0]    LP_BID     = (BANK_ID % 2 == 1) ? 2'b01 : 2'b00;

  entry_state_e           r_state     [N_ENTRY];
  entry_state_e           w_state_nxt [N_ENTRY];
  logic [LINE_ADDR_W-1:0] r_addr      [N_ENTRY];
  logic [N_ENTRY-1:0]     r_is_load;
  logic [N_ENTRY-1:0]     r_no_resp;
  logic [N_ENTRY-1:0]     w_no_resp_nxt;

  logic [ID_W-1:0]        r_fifo      [N_ENTRY];
  logic [ID_W-1:0]        r_head;
  logic [ID_W-1:0]        r_tail;
  logic [ID_W:0]          r_fifo_cnt;
  logic                   r_gap;
  logic [ID_W:0]          r_free_cnt;

  logic [N_ENTRY-1:0]     w_free_vec;
  logic [N_ENTRY-1:0]     w_sent_vec;
  logic [ID_W-1:0]        w_free_id;
  logic                   w_merge;
  logic                   w_alloc_fire;
  logic                   w_dealloc_ok;
  logic [ID_W-1:0]        w_head_id;
  logic                   w_fifo_empty;
  logic                   w_head_pend;
  logic                   w_stale_pop;
  logic                   w_ar_fire;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_head_dealloc;

  // Per-entry status vectors and the lowest FREE index, from registered state only.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_free_vec = '0;
    w_sent_vec = '0;
    w_free_id  = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      w_free_vec[i] = (r_state[i] == ST_FREE);
      w_sent_vec[i] = (r_state[i] == ST_SENT);
    end
    for (int i = N_ENTRY - 1; i >= 0; i--) begin
      if (w_free_vec[i]) w_free_id = ID_W'(i);
    end
  end

`ifdef RVH_L1D_MSHR_MERGE_EN
  logic [N_ENTRY-1:0] w_match_vec;
  logic [ID_W-1:0]    w_match_id;
  logic               w_merge_fire;

  // Find a live entry already tracking the requested line.
  always_comb begin
    w_match_vec = '0;
    w_match_id  = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      w_match_vec[i] = (r_state[i] != ST_FREE) && (r_addr[i] == bus.alloc_line_addr_i);
    end
    for (int i = N_ENTRY - 1; i >= 0; i--) begin
      if (w_match_vec[i]) w_match_id = ID_W'(i);
    end
  end

  assign w_merge        = bus.alloc_vld_i & (|w_match_vec);
  assign w_merge_fire   = w_merge & bus.alloc_rdy_o;
  assign bus.alloc_id_o = w_merge ? w_match_id : w_free_id;
`else
  assign w_merge        = 1'b0;
  assign bus.alloc_id_o = w_free_id;
`endif

  assign bus.alloc_merge_o = w_merge;
  assign bus.alloc_rdy_o   = (r_free_cnt != '0);
  assign w_alloc_fire      = bus.alloc_vld_i & bus.alloc_rdy_o & ~w_merge;
  assign w_dealloc_ok      = bus.dealloc_vld_i & (r_state[bus.dealloc_id_i] != ST_FREE);

  // Issue side: the FIFO head drives AR; a head that is no longer PEND is dropped silently.
  assign w_head_id      = r_fifo[r_head];
  assign w_fifo_empty   = (r_fifo_cnt == '0);
  assign w_head_pend    = (r_state[w_head_id] == ST_PEND);
  assign w_stale_pop    = ~w_fifo_empty & ~w_head_pend;
  assign bus.ar_vld_o   = ~w_fifo_empty & w_head_pend & ~r_gap;
  assign bus.ar_id_o    = w_head_id;
  assign bus.ar_addr_o  = r_addr[w_head_id];
  assign bus.ar_bid_o   = LP_BID;
  assign w_ar_fire      = bus.ar_vld_o & bus.ar_rdy_i;
  assign w_push         = w_alloc_fire & ~bus.alloc_no_fetch_i;
  assign w_pop          = w_ar_fire | w_stale_pop;
  assign w_head_dealloc = bus.dealloc_vld_i & (bus.dealloc_id_i == w_head_id);

  assign bus.entry_vld_o     = ~w_free_vec;
  assign bus.entry_sent_o    = w_sent_vec;
  assign bus.entry_no_resp_o = r_no_resp;
  assign bus.free_cnt_o      = r_free_cnt;

  // Next state of every entry FSM and its no_resp flag.
  always_comb begin
    w_no_resp_nxt = r_no_resp;
    for (int i = 0; i < N_ENTRY; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        ST_FREE: if (w_alloc_fire && bus.alloc_id_o == ID_W'(i))
                   w_state_nxt[i] = bus.alloc_no_fetch_i ? ST_HOLD : ST_PEND;
        ST_PEND: if (w_ar_fire && w_head_id == ID_W'(i))
                   w_state_nxt[i] = ST_SENT;
        default: ;
      endcase
      if (bus.dealloc_vld_i && bus.dealloc_id_i == ID_W'(i) && r_state[i] != ST_FREE)
        w_state_nxt[i] = ST_FREE;

      if (bus.rob_flush_i && r_state[i] != ST_FREE && r_is_load[i])
        w_no_resp_nxt[i] = 1'b1;
`ifdef RVH_L1D_MSHR_MERGE_EN
      if (w_merge_fire && bus.alloc_is_load_i && w_match_id == ID_W'(i))
        w_no_resp_nxt[i] = 1'b0;
`endif
      if (w_alloc_fire && bus.alloc_id_o == ID_W'(i))
        w_no_resp_nxt[i] = 1'b0;
    end
  end

  // Control state: entry FSMs, no_resp, FIFO pointers, gap counter, free count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      for (int i = 0; i < N_ENTRY; i++) r_state[i] <= ST_FREE;
      r_no_resp  <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_fifo_cnt <= '0;
      r_gap      <= 1'b0;
      r_free_cnt <= LP_N_ENTRY;
    end else begin
      for (int i = 0; i < N_ENTRY; i++) r_state[i] <= w_state_nxt[i];
      r_no_resp  <= w_no_resp_nxt;
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      r_fifo_cnt <= r_fifo_cnt + (ID_W+1)'(w_push) - (ID_W+1)'(w_pop);
      r_gap      <= w_ar_fire ? LP_GAP : 1'b0;
      r_free_cnt <= r_free_cnt - (ID_W+1)'(w_alloc_fire) + (ID_W+1)'(w_dealloc_ok);
    end
  end

  // Entry payload and FIFO storage, written only on allocation.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are not reset; valid state alone decides whether their contents are used.
    if (w_alloc_fire) begin
      r_addr[bus.alloc_id_o]    <= bus.alloc_line_addr_i;
      r_is_load[bus.alloc_id_o] <= bus.alloc_is_load_i;
    end
    if (w_push) r_fifo[r_tail] <= bus.alloc_id_o;
  end

`ifndef SYNTHESIS
  logic                   r_chk_hold;
  logic [ID_W-1:0]        r_chk_id;
  logic [LINE_ADDR_W-1:0] r_chk_addr;

  // Protocol checks: grant only FREE entries, no FIFO overflow, stable AR payload while stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_chk_hold <= 1'b0;
    end else begin
      r_chk_hold <= bus.ar_vld_o & ~bus.ar_rdy_i & ~w_head_dealloc;
      r_chk_id   <= bus.ar_id_o;
      r_chk_addr <= bus.ar_addr_o;
      if (w_alloc_fire) assert (w_free_vec[bus.alloc_id_o]);
      if (w_push && !w_pop) assert (r_fifo_cnt != LP_N_ENTRY);
      if (r_chk_hold) assert (bus.ar_vld_o && bus.ar_id_o == r_chk_id && bus.ar_addr_o == r_chk_addr);
    end
  end
`endif

endmodule
